stream_serializer: RTL and testbench

Transmit-side counterpart of the serial pattern detector. It accepts parallel words over a valid/ready handshake and shifts each word out MSB-first, one bit per clock, on a single-bit `stream` line with a qualifying `stream_valid`. It drives the detector's `stream` input, both in the bench and in the top-level loopback, with optional inter-word idle gaps and an optional parity bit.

---
 rtl/stream_pkg.sv | 24 ++
 rtl/stream_serializer.sv | 219 +++++++++++++++++++++
 tb/tb_stream_serializer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pkg
// Purpose  : Shared types and constants for the serial stream blocks.
//            - ser_state_t   : serializer state encoding
//            - STREAM_WORD_W : default parallel word width
// Revision : 1.0  initial release
// ============================================================================
package stream_pkg;

    // Default parallel word width shared by the stream serializer and detector.
    localparam int STREAM_WORD_W = 32;

    // Serializer states. The encoding is fixed so the state register is
    // always 2 bits wide, independent of which states are reachable.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } ser_state_t;

endpackage : stream_pkg
`default_nettype wire

// File: rtl/stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : stream_serializer
// Purpose  : Accepts parallel words over a valid/ready handshake and shifts
//            each word out MSB-first, one bit per clock, on a registered
//            single-bit stream with a qualifying stream_valid. Optional idle
//            gap between frames and optional trailing even-parity bit.
//
// Build option:
//   STREAM_SERIALIZER_PARITY_EN  defined   -> every frame ends with the
//                                             even-parity bit of the word
//                                undefined -> frame is exactly WORD_W bits
//
// Parameters:
//   WORD_W      word width in bits (>= 2)
//   GAP_CYCLES  idle cycles between frames (0 = back-to-back frames)
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   word_in       in   parallel word, bit WORD_W-1 is sent first
//   word_valid    in   word_in is offered
//   word_ready    out  word_in is accepted this cycle (no path from word_valid)
//   stream        out  serial data bit, registered, 0 when not valid
//   stream_valid  out  stream carries a frame bit, registered
//   last_bit      out  current stream bit is the last bit of the frame
//   busy          out  serializer is not idle
//
// Revision : 1.0  initial release
// ============================================================================
module stream_serializer
    import stream_pkg::*;
#(
    parameter int WORD_W     = STREAM_WORD_W,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              stream,
    output logic              stream_valid,
    output logic              last_bit,
    output logic              busy
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] c_GAP_ONE  = GAP_W'(1);

    // The IDLE cycle in which the next word is accepted is itself one of the
    // idle cycles between frames, so the GAP state only covers the remaining
    // GAP_CYCLES-1 cycles. With GAP_CYCLES <= 1 the GAP state is skipped.
    localparam logic [GAP_W-1:0] c_GAP_LOAD =
        (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 2) : '0;
    localparam ser_state_t c_POST_FRAME = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
    localparam bit c_BACK_TO_BACK = (GAP_CYCLES == 0);

`ifdef STREAM_SERIALIZER_PARITY_EN
    localparam bit c_PARITY_EN = 1'b1;
`else
    localparam bit c_PARITY_EN = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    ser_state_t        r_state;
    logic [WORD_W-1:0] r_shift;        // bits still to be sent, next one at MSB
    logic [CNT_W-1:0]  r_bit_cnt;      // index of the bit currently on stream
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_stream;
    logic              r_stream_valid;
    logic              r_last_bit;
`ifdef STREAM_SERIALIZER_PARITY_EN
    logic              r_parity;       // even parity of the word in flight
    logic              w_parity_nxt;
`endif

    ser_state_t        w_state_nxt;
    logic [WORD_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic [GAP_W-1:0]  w_gap_cnt_nxt;
    logic              w_stream_nxt;
    logic              w_stream_valid_nxt;
    logic              w_last_bit_nxt;
    logic              w_final_bit;
    logic              w_xfer;

    // ------------------------------------------------------------------------
    // Handshake: ready depends on state/counter only. The final bit cycle of
    // a frame is also ready when frames may run back-to-back. Ready is held
    // low while reset is asserted so no word is taken during reset.
    // ------------------------------------------------------------------------
`ifdef STREAM_SERIALIZER_PARITY_EN
    assign w_final_bit = (r_state == ST_PARITY);
`else
    assign w_final_bit = (r_state == ST_SHIFT) && (r_bit_cnt == '0);
`endif

    assign word_ready = !rst &&
                        ((r_state == ST_IDLE) || (c_BACK_TO_BACK && w_final_bit));
    assign w_xfer     = word_valid && word_ready;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        w_shift_nxt        = r_shift;
        w_bit_cnt_nxt      = r_bit_cnt;
        w_gap_cnt_nxt      = r_gap_cnt;
        w_stream_nxt       = 1'b0;
        w_stream_valid_nxt = 1'b0;
        w_last_bit_nxt     = 1'b0;
`ifdef STREAM_SERIALIZER_PARITY_EN
        w_parity_nxt       = r_parity;
`endif

        case (r_state)
            ST_SHIFT: begin
                if (r_bit_cnt != '0) begin
                    w_stream_nxt       = r_shift[WORD_W-1];
                    w_stream_valid_nxt = 1'b1;
                    w_shift_nxt        = {r_shift[WORD_W-2:0], 1'b0};
                    w_bit_cnt_nxt      = r_bit_cnt - c_CNT_ONE;
                    // The LSB closes the frame only when no parity follows.
                    w_last_bit_nxt     = !c_PARITY_EN && (r_bit_cnt == c_CNT_ONE);
                end else begin
`ifdef STREAM_SERIALIZER_PARITY_EN
                    w_state_nxt        = ST_PARITY;
                    w_stream_nxt       = r_parity;
                    w_stream_valid_nxt = 1'b1;
                    w_last_bit_nxt     = 1'b1;
`else
                    w_state_nxt        = c_POST_FRAME;
                    w_gap_cnt_nxt      = c_GAP_LOAD;
`endif
                end
            end

            ST_PARITY: begin
`ifdef STREAM_SERIALIZER_PARITY_EN
                w_state_nxt   = c_POST_FRAME;
                w_gap_cnt_nxt = c_GAP_LOAD;
`else
                w_state_nxt   = ST_IDLE;
`endif
            end

            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - c_GAP_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A transfer overrides everything: it happens in IDLE or in the final
        // bit cycle, and the new MSB goes out directly in the next cycle.
        if (w_xfer) begin
            w_state_nxt        = ST_SHIFT;
            w_stream_nxt       = word_in[WORD_W-1];
            w_stream_valid_nxt = 1'b1;
            w_last_bit_nxt     = 1'b0;
            w_shift_nxt        = {word_in[WORD_W-2:0], 1'b0};
            w_bit_cnt_nxt      = c_CNT_LAST;
            w_gap_cnt_nxt      = '0;
`ifdef STREAM_SERIALIZER_PARITY_EN
            w_parity_nxt       = ^word_in;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_stream       <= 1'b0;
            r_stream_valid <= 1'b0;
            r_last_bit     <= 1'b0;
`ifdef STREAM_SERIALIZER_PARITY_EN
            r_parity       <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_shift        <= w_shift_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_gap_cnt      <= w_gap_cnt_nxt;
            r_stream       <= w_stream_nxt;
            r_stream_valid <= w_stream_valid_nxt;
            r_last_bit     <= w_last_bit_nxt;
`ifdef STREAM_SERIALIZER_PARITY_EN
            r_parity       <= w_parity_nxt;
`endif
        end
    end

    assign stream       = r_stream;
    assign stream_valid = r_stream_valid;
    assign last_bit     = r_last_bit;
    assign busy         = (r_state != ST_IDLE);

endmodule : stream_serializer
`default_nettype wire

// File: tb/tb_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_serializer
// Purpose  : Directed self-checking bench for stream_serializer. Two
//            instances share clk/rst: one with GAP_CYCLES=0, one with
//            GAP_CYCLES=3. Expected frames follow the parity build option.
// Revision : 1.0  initial release
// ============================================================================
module tb_stream_serializer;

`ifdef STREAM_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
    localparam logic [127:0] c_EXP_CCB2 = 128'h1_9965_5B5F;  // CCB2ADAF, parity 1
`else
    localparam int PAR = 0;
    localparam logic [127:0] c_EXP_CCB2 = 128'hCCB2_ADAF;
`endif
    localparam int F = 32 + PAR;  // frame length in cycles

    logic        clk;
    logic        rst;
    logic [31:0] r_word0, r_word3;
    logic        r_valid0, r_valid3;
    logic        w_ready0, w_stream0, w_sv0, w_last0, w_busy0;
    logic        w_ready3, w_stream3, w_sv3, w_last3, w_busy3;

    int n_assert = 0;
    int n_fail   = 0;

    logic [127:0] cap_bits, cap_valid, cap_last, cap_ready, cap_busy;

    stream_serializer #(.WORD_W(32), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .word_in(r_word0), .word_valid(r_valid0),
        .word_ready(w_ready0), .stream(w_stream0), .stream_valid(w_sv0),
        .last_bit(w_last0), .busy(w_busy0)
    );

    stream_serializer #(.WORD_W(32), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .word_in(r_word3), .word_valid(r_valid3),
        .word_ready(w_ready3), .stream(w_stream3), .stream_valid(w_sv3),
        .last_bit(w_last3), .busy(w_busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected serial frame of a word, MSB first, parity appended when built in.
    function automatic logic [127:0] fr(input logic [31:0] w);
`ifdef STREAM_SERIALIZER_PARITY_EN
        return {95'b0, w, ^w};
`else
        return {96'b0, w};
`endif
    endfunction

    function automatic logic [127:0] ones(input int k);
        return (128'd1 << k) - 128'd1;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples n cycles (#1 after each edge) into cap_*; cycle i is stored at
    // bit n-1-i so the captured bits read MSB-first. Inputs are changed right
    // after sampling so they apply at the following edge.
    task automatic capture(input bit use3, input int n, input int swap_at,
                           input logic [31:0] swap_word, input int clear_at,
                           input int toggle_until);
        cap_bits = '0; cap_valid = '0; cap_last = '0; cap_ready = '0; cap_busy = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cap_bits[n-1-i]  = use3 ? w_stream3 : w_stream0;
            cap_valid[n-1-i] = use3 ? w_sv3     : w_sv0;
            cap_last[n-1-i]  = use3 ? w_last3   : w_last0;
            cap_ready[n-1-i] = use3 ? w_ready3  : w_ready0;
            cap_busy[n-1-i]  = use3 ? w_busy3   : w_busy0;
            if (i == swap_at) begin
                if (use3) r_word3 = swap_word; else r_word0 = swap_word;
            end
            if (i == clear_at) begin
                if (use3) r_valid3 = 1'b0; else r_valid0 = 1'b0;
            end
            if (toggle_until > 0) begin
                if (i < toggle_until) begin
                    r_valid0 = (i % 2 == 1);
                    r_word0  = 32'hDEAD_0000 | 32'(i);
                end else begin
                    r_valid0 = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        r_word0 = '0; r_word3 = '0; r_valid0 = 1'b0; r_valid3 = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", w_ready0, 0);
        check("rst_valid", w_sv0, 0);
        check("rst_busy", w_busy0, 0);
        check("rst_stream", w_stream0, 0);
        check("rst_last", w_last0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready0", w_ready0, 1);
        check("post_rst_ready3", w_ready3, 1);

        // ---------------- single word CCB2ADAF ----------------
        r_word0 = 32'hCCB2_ADAF; r_valid0 = 1'b1;
        capture(0, F, -1, 32'h0, 0, 0);
        check("w1_first32", (cap_bits >> PAR) & ones(32), 128'b11001100101100101010110110101111);
        check("w1_frame", cap_bits, c_EXP_CCB2);
        check("w1_valid", cap_valid, ones(F));
        check("w1_last", cap_last, 128'd1);
        check("w1_ready", cap_ready, 128'd1);
        check("w1_busy", cap_busy, ones(F));
        @(posedge clk); #1;
        check("w1_end_valid", w_sv0, 0);
        check("w1_end_stream", w_stream0, 0);
        check("w1_end_busy", w_busy0, 0);
        check("w1_end_ready", w_ready0, 1);

        // ---------------- back-to-back FFFF0000 / 0000FFFF ----------------
        r_word0 = 32'hFFFF_0000; r_valid0 = 1'b1;
        capture(0, 2*F, 0, 32'h0000_FFFF, F, 0);
        check("b2b_bits", cap_bits, (fr(32'hFFFF_0000) << F) | fr(32'h0000_FFFF));
        check("b2b_valid", cap_valid, ones(2*F));
        check("b2b_last", cap_last, (128'd1 << F) | 128'd1);
        check("b2b_ready", cap_ready, (128'd1 << F) | 128'd1);
        @(posedge clk); #1;
        check("b2b_end_valid", w_sv0, 0);

        // ---------------- GAP_CYCLES=3, two words ----------------
        r_word3 = 32'hA5A5_0F0F; r_valid3 = 1'b1;
        capture(1, 2*F+3, 0, 32'h1234_5678, F+3, 0);
        check("gap_bits", cap_bits, (fr(32'hA5A5_0F0F) << (F+3)) | fr(32'h1234_5678));
        check("gap_valid", cap_valid, ones(2*F+3) & ~(128'd7 << F));
        check("gap_last", cap_last, (128'd1 << (F+3)) | 128'd1);
        check("gap_ready", cap_ready, 128'd1 << F);
        check("gap_busy", cap_busy, ones(2*F+3) & ~(128'd1 << F));

        // ---------------- reset at bit 10 ----------------
        repeat (4) @(posedge clk);
        #1;
        r_word0 = 32'h8421_F00D; r_valid0 = 1'b1;
        capture(0, 10, -1, 32'h0, 0, 0);
        check("rstmid_bits", cap_bits & ones(10), 128'h210);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rstmid_valid", w_sv0, 0);
        check("rstmid_busy", w_busy0, 0);
        check("rstmid_ready", w_ready0, 1);
        check("rstmid_stream", w_stream0, 0);
        check("rstmid_last", w_last0, 0);
        r_word0 = 32'h5A5A_C3C3; r_valid0 = 1'b1;
        capture(0, F, -1, 32'h0, 0, 0);
        check("rstmid_new_bits", cap_bits, fr(32'h5A5A_C3C3));
        check("rstmid_new_valid", cap_valid, ones(F));

        // ---------------- word_valid toggling while busy ----------------
        @(posedge clk); #1;
        r_word0 = 32'h3C3C_9669; r_valid0 = 1'b1;
        capture(0, F, -1, 32'h0, -1, F-2);
        check("tog_bits", cap_bits, fr(32'h3C3C_9669));
        check("tog_valid", cap_valid, ones(F));
        check("tog_last", cap_last, 128'd1);
        check("tog_ready", cap_ready, 128'd1);
        @(posedge clk); #1;
        check("tog_end_busy", w_busy0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_stream_serializer
`default_nettype wire
